// File: rtl/voxel_frame_sequencer.sv
// Frame sequencer: streams voxels to the shader array, triggers shading, then scans pixels out to the framebuffer.
// Optional macro SEQ_WATCHDOG_EN adds a stuck-handshake watchdog and the watchdog_err port.
module voxel_frame_sequencer #(
   parameter int unsigned COORD_BITS   = 8,
   parameter int unsigned PALETTE_BITS = 8,
   parameter int unsigned ADDR_BITS    = 10,
   parameter int unsigned ROWS         = 4,
   parameter int unsigned COLS         = 4,
   parameter int unsigned ROW_BITS     = 8,
   parameter int unsigned COL_BITS     = 8,
   parameter int unsigned PIXEL_BITS   = 8,
   parameter int unsigned FB_ADDR_BITS = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [ADDR_BITS:0]                    voxel_count,
   output logic [ADDR_BITS-1:0]                  mem_addr,
   output logic                                  mem_rd,
   input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  mem_rdata,
   output logic [COORD_BITS-1:0]                 voxel_x,
   output logic [COORD_BITS-1:0]                 voxel_y,
   output logic [COORD_BITS-1:0]                 voxel_z,
   output logic [PALETTE_BITS-1:0]               voxel_id,
   output logic                                  do_rasterize,
   output logic                                  do_shade,
   input  logic                                  rasterizing_done_all,
   input  logic                                  shading_done_all,
   output logic [ROW_BITS-1:0]                   row,
   output logic [COL_BITS-1:0]                   col,
   input  logic [PIXEL_BITS-1:0]                 pixel,
   output logic                                  fb_valid,
   input  logic                                  fb_ready,
   output logic [FB_ADDR_BITS-1:0]               fb_addr,
   output logic [PIXEL_BITS-1:0]                 fb_data,
   output logic                                  busy,
   output logic                                  frame_done
`ifdef SEQ_WATCHDOG_EN
   ,
   output logic                                  watchdog_err
`endif
);

   localparam int unsigned WORD_BITS = 3*COORD_BITS + PALETTE_BITS;
   localparam int unsigned CNT_BITS  = ADDR_BITS + 1;
   localparam int unsigned WD_BITS   = 16;
   localparam logic [CNT_BITS-1:0] MAX_COUNT = CNT_BITS'(2**ADDR_BITS);

   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, RASTER, R_RELEASE, SHADE, S_RELEASE, SCAN_SEL, SCAN_PUSH, DONE
   } state_t;

   state_t                   state, state_nxt;
   logic [CNT_BITS-1:0]      idx, idx_nxt;
   logic [CNT_BITS-1:0]      count, count_nxt, count_in;
   logic [WORD_BITS-1:0]     vox, vox_nxt;
   logic [ROW_BITS-1:0]      row_nxt;
   logic [COL_BITS-1:0]      col_nxt;
   logic [FB_ADDR_BITS-1:0]  fb_addr_nxt;
   logic [PIXEL_BITS-1:0]    fb_data_nxt;
   logic [ADDR_BITS-1:0]     mem_addr_nxt;
   logic                     mem_rd_nxt, do_rasterize_nxt, do_shade_nxt;
   logic                     fb_valid_nxt, busy_nxt, frame_done_nxt;
   logic                     last_col, last_row;
`ifdef SEQ_WATCHDOG_EN
   logic [WD_BITS-1:0]       wd_cnt, wd_cnt_nxt;
   logic                     wd_err_nxt, watched;
`endif

   assign voxel_x  = vox[COORD_BITS-1:0];
   assign voxel_y  = vox[2*COORD_BITS-1:COORD_BITS];
   assign voxel_z  = vox[3*COORD_BITS-1:2*COORD_BITS];
   assign voxel_id = vox[WORD_BITS-1:3*COORD_BITS];

   assign last_col = (col == COL_BITS'(COLS-1));
   assign last_row = (row == ROW_BITS'(ROWS-1));
   assign count_in = (voxel_count > MAX_COUNT) ? MAX_COUNT : voxel_count;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      count_nxt   = count;
      vox_nxt     = vox;
      row_nxt     = row;
      col_nxt     = col;
      fb_addr_nxt = fb_addr;
      fb_data_nxt = fb_data;
`ifdef SEQ_WATCHDOG_EN
      wd_err_nxt  = watchdog_err;
      wd_cnt_nxt  = wd_cnt;
      watched     = (state == RASTER) || (state == R_RELEASE) ||
                    (state == SHADE)  || (state == S_RELEASE);
`endif
      case (state)
         IDLE: begin
            if (start) begin
               count_nxt = count_in;
               idx_nxt   = '0;
`ifdef SEQ_WATCHDOG_EN
               wd_err_nxt = 1'b0;
`endif
               state_nxt = (count_in == '0) ? SHADE : FETCH;
            end
         end
         FETCH: state_nxt = LOAD;
         LOAD: begin
            vox_nxt   = mem_rdata;
            state_nxt = RASTER;
         end
         RASTER: if (rasterizing_done_all) state_nxt = R_RELEASE;
         R_RELEASE: begin
            if (!rasterizing_done_all) begin
               idx_nxt   = idx + CNT_BITS'(1);
               state_nxt = (idx_nxt < count) ? FETCH : SHADE;
            end
         end
         SHADE: if (shading_done_all) state_nxt = S_RELEASE;
         S_RELEASE: begin
            if (!shading_done_all) begin
               row_nxt   = '0;
               col_nxt   = '0;
               state_nxt = SCAN_SEL;
            end
         end
         SCAN_SEL: begin
            fb_data_nxt = pixel;
            fb_addr_nxt = FB_ADDR_BITS'(row) * FB_ADDR_BITS'(COLS) + FB_ADDR_BITS'(col);
            state_nxt   = SCAN_PUSH;
         end
         SCAN_PUSH: begin
            if (fb_ready) begin
               if (last_col) begin
                  col_nxt = '0;
                  row_nxt = last_row ? '0 : row + ROW_BITS'(1);
               end else begin
                  col_nxt = col + COL_BITS'(1);
               end
               state_nxt = (last_col && last_row) ? DONE : SCAN_SEL;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
`ifdef SEQ_WATCHDOG_EN
      // A handshake stuck for the full counter range abandons the frame
      if (watched && (wd_cnt == {WD_BITS{1'b1}})) begin
         state_nxt  = DONE;
         wd_err_nxt = 1'b1;
      end
      if (state_nxt != state)
         wd_cnt_nxt = '0;
      else if (watched)
         wd_cnt_nxt = wd_cnt + WD_BITS'(1);
`endif
      mem_rd_nxt       = (state_nxt == FETCH);
      mem_addr_nxt     = idx_nxt[ADDR_BITS-1:0];
      do_rasterize_nxt = (state_nxt == RASTER);
      do_shade_nxt     = (state_nxt == SHADE);
      fb_valid_nxt     = (state_nxt == SCAN_PUSH);
      busy_nxt         = (state_nxt != IDLE);
      frame_done_nxt   = (state_nxt == DONE);
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         idx          <= '0;
         count        <= '0;
         vox          <= '0;
         row          <= '0;
         col          <= '0;
         fb_addr      <= '0;
         fb_data      <= '0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         do_rasterize <= 1'b0;
         do_shade     <= 1'b0;
         fb_valid     <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
         wd_cnt       <= '0;
         watchdog_err <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         count        <= count_nxt;
         vox          <= vox_nxt;
         row          <= row_nxt;
         col          <= col_nxt;
         fb_addr      <= fb_addr_nxt;
         fb_data      <= fb_data_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_rd       <= mem_rd_nxt;
         do_rasterize <= do_rasterize_nxt;
         do_shade     <= do_shade_nxt;
         fb_valid     <= fb_valid_nxt;
         busy         <= busy_nxt;
         frame_done   <= frame_done_nxt;
`ifdef SEQ_WATCHDOG_EN
         wd_cnt       <= wd_cnt_nxt;
         watchdog_err <= wd_err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// Self-checking bench for voxel_frame_sequencer: memory, shader and framebuffer models with a frame-level reference.
// Watchdog scenario is compiled in when SEQ_WATCHDOG_EN is defined.
module tb_voxel_frame_sequencer;

   localparam int unsigned COORD_BITS   = 8;
   localparam int unsigned PALETTE_BITS = 8;
   localparam int unsigned ADDR_BITS    = 10;
   localparam int unsigned ROWS         = 4;
   localparam int unsigned COLS         = 4;
   localparam int unsigned ROW_BITS     = 8;
   localparam int unsigned COL_BITS     = 8;
   localparam int unsigned PIXEL_BITS   = 8;
   localparam int unsigned FB_ADDR_BITS = 16;
   localparam int unsigned WORD_BITS    = 3*COORD_BITS + PALETTE_BITS;
   localparam int unsigned NPIX         = ROWS*COLS;
   localparam int unsigned MEM_WORDS    = 2**ADDR_BITS;

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   logic                     start = 1'b0;
   logic [ADDR_BITS:0]       voxel_count = '0;
   logic [ADDR_BITS-1:0]     mem_addr;
   logic                     mem_rd;
   logic [WORD_BITS-1:0]     mem_rdata = '0;
   logic [COORD_BITS-1:0]    voxel_x, voxel_y, voxel_z;
   logic [PALETTE_BITS-1:0]  voxel_id;
   logic                     do_rasterize, do_shade;
   logic                     rasterizing_done_all = 1'b0;
   logic                     shading_done_all = 1'b0;
   logic [ROW_BITS-1:0]      row;
   logic [COL_BITS-1:0]      col;
   logic [PIXEL_BITS-1:0]    pixel;
   logic                     fb_valid;
   logic                     fb_ready = 1'b1;
   logic [FB_ADDR_BITS-1:0]  fb_addr;
   logic [PIXEL_BITS-1:0]    fb_data;
   logic                     busy, frame_done;
`ifdef SEQ_WATCHDOG_EN
   logic                     watchdog_err;
`endif

   voxel_frame_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .voxel_count(voxel_count),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
      .do_rasterize(do_rasterize), .do_shade(do_shade),
      .rasterizing_done_all(rasterizing_done_all), .shading_done_all(shading_done_all),
      .row(row), .col(col), .pixel(pixel),
      .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .frame_done(frame_done)
`ifdef SEQ_WATCHDOG_EN
      , .watchdog_err(watchdog_err)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Voxel memory: one-cycle read latency
   logic [WORD_BITS-1:0] mem [MEM_WORDS];
   always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

   // Shader array and framebuffer behaviour
   int  r_lat = 0, r_rel = 0, rc = 0, fc = 0, sc = 0, sfc = 0;
   bit  tie_low = 1'b0;
   bit  rdy_rand = 1'b0;
   logic [PIXEL_BITS-1:0] salt = '0;

   always_comb pixel = PIXEL_BITS'(32'(row) * 16 + 32'(col)) ^ salt;

   always @(posedge clock) begin
      #1;
      if (do_rasterize) begin
         fc = 0;
         if (!tie_low) begin
            if (rc >= r_lat) rasterizing_done_all = 1'b1; else rc++;
         end
      end else begin
         rc = 0;
         if (rasterizing_done_all) begin
            if (fc >= r_rel) rasterizing_done_all = 1'b0; else fc++;
         end
      end
      if (do_shade) begin
         sfc = 0;
         if (sc >= r_lat) shading_done_all = 1'b1; else sc++;
      end else begin
         sc = 0;
         if (shading_done_all) begin
            if (sfc >= r_rel) shading_done_all = 1'b0; else sfc++;
         end
      end
      fb_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Observation: pulse counts, per-cycle voxel bus, stall stability, fb transfers
   int r_pulses = 0, s_pulses = 0, mem_rds = 0, done_cnt = 0, rast_cycles = 0;
   logic prev_rast = 1'b0, prev_shade = 1'b0, prev_stall = 1'b0;
   logic [FB_ADDR_BITS-1:0] prev_addr = '0;
   logic [PIXEL_BITS-1:0]   prev_data = '0;
   int fbq_addr[$];
   int fbq_data[$];

   always @(negedge clock) begin
      if (do_rasterize && do_shade) chk("rast_shade_overlap", 1, 0);
      if (mem_rd) begin
         chk("mem_addr_seq", 64'(mem_addr), 64'(mem_rds % MEM_WORDS));
         mem_rds++;
      end
      if (do_rasterize) begin
         if (!prev_rast) r_pulses++;
         rast_cycles++;
         chk("voxel_bus", 64'({voxel_id, voxel_z, voxel_y, voxel_x}),
             64'(mem[ADDR_BITS'(r_pulses - 1)]));
      end
      if (do_shade && !prev_shade) s_pulses++;
      if (prev_stall && reset) begin
         chk("stall_valid", 64'(fb_valid), 64'(1));
         chk("stall_addr", 64'(fb_addr), 64'(prev_addr));
         chk("stall_data", 64'(fb_data), 64'(prev_data));
      end
      if (fb_valid && fb_ready) begin
         fbq_addr.push_back(int'(fb_addr));
         fbq_data.push_back(int'(fb_data));
      end
      if (frame_done) done_cnt++;
      prev_stall = fb_valid && !fb_ready;
      prev_addr  = fb_addr;
      prev_data  = fb_data;
      prev_rast  = do_rasterize;
      prev_shade = do_shade;
   end

   function automatic logic [PIXEL_BITS-1:0] exp_pix(input int a);
      return PIXEL_BITS'((a / COLS) * 16 + (a % COLS)) ^ salt;
   endfunction

   task automatic clear_obs();
      r_pulses = 0; s_pulses = 0; mem_rds = 0; done_cnt = 0; rast_cycles = 0;
      fbq_addr.delete();
      fbq_data.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_rd"}, 64'(mem_rd), 0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
      chk({tag, "_voxel"}, 64'({voxel_id, voxel_z, voxel_y, voxel_x}), 0);
      chk({tag, "_do_rast"}, 64'(do_rasterize), 0);
      chk({tag, "_do_shade"}, 64'(do_shade), 0);
      chk({tag, "_rowcol"}, 64'({row, col}), 0);
      chk({tag, "_fb"}, 64'({fb_valid, fb_addr, fb_data}), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_frame_done"}, 64'(frame_done), 0);
   endtask

   // One frame against the reference: n_exp voxels in memory order, one shade, full raster-order scan
   task automatic run_frame(input string tag, input int n_req, input int n_exp, input bit hold_start);
      int cyc, budget;
      budget = 300 + n_exp * (2 * r_lat + 2 * r_rel + 12) + NPIX * 40;
      clear_obs();
      @(negedge clock);
      start = 1'b1;
      voxel_count = (ADDR_BITS+1)'(n_req);
      @(negedge clock);
      chk({tag, "_busy_after_start"}, 64'(busy), 1);
      if (hold_start) voxel_count = (ADDR_BITS+1)'($urandom_range(1, 9));
      else start = 1'b0;
      cyc = 0;
      while (!frame_done && cyc < budget) begin
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_frame_timeout"}, 64'(cyc < budget), 1);
      @(negedge clock);
      @(negedge clock);
      chk({tag, "_busy_idle"}, 64'(busy), 0);
      chk({tag, "_done_pulses"}, 64'(done_cnt), 1);
      chk({tag, "_rast_pulses"}, 64'(r_pulses), 64'(n_exp));
      chk({tag, "_mem_reads"}, 64'(mem_rds), 64'(n_exp));
      chk({tag, "_shade_pulses"}, 64'(s_pulses), 1);
      chk({tag, "_fb_count"}, 64'(fbq_addr.size()), 64'(NPIX));
      for (int i = 0; i < NPIX && i < fbq_addr.size(); i++) begin
         chk({tag, "_fb_addr"}, 64'(fbq_addr[i]), 64'(i));
         chk({tag, "_fb_data"}, 64'(fbq_data[i]), 64'(exp_pix(i)));
      end
   endtask

   initial begin
      int n, rises, cyc;
      logic pr;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = WORD_BITS'($urandom);

      // Reset state
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Directed frame: three known voxels, fixed latency, always-ready framebuffer
      mem[0] = {8'd5, 8'd3, 8'd2, 8'd1};
      mem[1] = {8'd7, 8'd6, 8'd5, 8'd4};
      mem[2] = {8'd1, 8'd0, 8'd0, 8'd0};
      r_lat = 3; r_rel = 0; rdy_rand = 1'b0; salt = '0;
      run_frame("three_voxels", 3, 3, 1'b0);

      // Empty frame straight to shading, with framebuffer back-pressure
      r_lat = 1; r_rel = 1; rdy_rand = 1'b1; salt = PIXEL_BITS'($urandom);
      run_frame("zero_voxels", 0, 0, 1'b0);

      // Randomised frames; one holds start (and changes voxel_count) while busy
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) mem[i] = WORD_BITS'($urandom);
         n = $urandom_range(1, 6);
         r_lat = $urandom_range(0, 3);
         r_rel = $urandom_range(0, 2);
         rdy_rand = 1'($urandom_range(0, 1));
         salt = PIXEL_BITS'($urandom);
         run_frame("random_frame", n, n, k == 1);
      end

      // Reset while voxel 2 is being rasterized, then replay from voxel 0
      r_lat = 3; r_rel = 0; rdy_rand = 1'b0;
      clear_obs();
      @(negedge clock);
      start = 1'b1;
      voxel_count = (ADDR_BITS+1)'(3);
      @(negedge clock);
      start = 1'b0;
      rises = 0; cyc = 0; pr = 1'b0;
      while (cyc < 200) begin
         if (do_rasterize && !pr) rises++;
         if (rises == 2 && do_rasterize) break;
         pr = do_rasterize;
         @(negedge clock);
         cyc++;
      end
      chk("midreset_reach_voxel2", 64'(cyc < 200), 1);
      reset = 1'b0;
      @(negedge clock);
      check_zero("midreset");
      reset = 1'b1;
      repeat (4) @(negedge clock);
      chk("midreset_no_done", 64'(done_cnt), 0);
      run_frame("replay", 3, 3, 1'b0);

      // Oversized voxel_count clamps to the full memory
      r_lat = 0; r_rel = 0; rdy_rand = 1'b0;
      run_frame("clamp", 2**(ADDR_BITS+1) - 1, MEM_WORDS, 1'b0);

`ifdef SEQ_WATCHDOG_EN
      // Rasterizer never answers: watchdog abandons the frame
      tie_low = 1'b1;
      clear_obs();
      @(negedge clock);
      start = 1'b1;
      voxel_count = (ADDR_BITS+1)'(1);
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!frame_done && cyc < 70000) begin
         @(negedge clock);
         cyc++;
      end
      chk("wd_timeout_reached", 64'(cyc < 70000), 1);
      chk("wd_rast_dropped", 64'(do_rasterize), 0);
      chk("wd_err_set", 64'(watchdog_err), 1);
      tie_low = 1'b0;
      repeat (2) @(negedge clock);
      chk("wd_rast_cycles", 64'(rast_cycles >= 65535 && rast_cycles <= 65536), 1);
      chk("wd_no_shade", 64'(s_pulses), 0);
      chk("wd_no_fb", 64'(fbq_addr.size()), 0);
      chk("wd_err_sticky", 64'(watchdog_err), 1);
      run_frame("wd_recover", 1, 1, 1'b0);
      chk("wd_err_cleared", 64'(watchdog_err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
